// File: rtl/sample_sram_writer.sv
// Sample buffer and SRAM write sequencer. Queues 16-bit samples in a small FIFO and
// commits them one word at a time to the SRAM controller, walking a circular window
// of word addresses. Sticky flags report dropped samples and address wrap-around.
module sample_sram_writer #(
    parameter int unsigned FIFO_AW   = 3,
    parameter logic [20:0] BASE_ADDR = 21'h000000,
    parameter logic [20:0] LAST_ADDR = 21'h1FFFFF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_sample_valid,
    input  logic [15:0]      i_sample_data,
    input  logic             i_sram_busy,
    output logic [20:0]      o_sram_addr,
    output logic [15:0]      o_sram_data,
    output logic             o_sram_wr,
    output logic             o_sram_re,
    output logic [FIFO_AW:0] o_fifo_level,
    output logic [20:0]      o_write_count,
    output logic             o_overflow,
    output logic             o_wrapped
);

    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned LW    = FIFO_AW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StSettle, StWait} state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [15:0]        r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;

    logic [20:0]        r_sram_addr;
    logic [15:0]        r_sram_data;
    logic               r_sram_wr;
    logic [20:0]        r_next_addr;
    logic [20:0]        r_write_count;
    logic               r_overflow;
    logic               r_wrapped;
    logic               r_clear_pend;

    logic               w_clear_now;
    logic               w_full;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_commit;
    logic               w_at_last;
    logic [20:0]        w_addr_adv;

    // A clear (fresh or pending) only takes effect while the sequencer is idle.
    assign w_clear_now = (r_state == StIdle) & (i_clear | r_clear_pend);
    // Fullness is judged on start-of-cycle occupancy, so a same-cycle pop never makes room.
    assign w_full      = (r_level == LW'(DEPTH));
    assign w_push_req  = i_sample_valid & i_enable & ~i_clear & ~w_clear_now;
    assign w_push      = w_push_req & ~w_full;
    assign w_drop      = w_push_req & w_full;
    assign w_commit    = (r_state == StWait) & ~i_sram_busy;
    assign w_at_last   = (r_next_addr == LAST_ADDR);
    assign w_addr_adv  = w_at_last ? BASE_ADDR : r_next_addr + 21'd1;

    // Next-state logic and pop decision for the write sequencer.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_clear_now && (r_level != '0) && !i_sram_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = StIssue;
                end
            end
            StIssue:  w_state_next = StSettle;
            // Controller busy is registered, so it cannot reflect our write yet.
            StSettle: w_state_next = StWait;
            StWait: begin
                if (!i_sram_busy) begin
                    w_state_next = StIdle;
                end
            end
            default:  w_state_next = StIdle;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_push) begin
            r_mem[r_wr_ptr] <= i_sample_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clear_now) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // Controller request registers: address/data latched on pop and held until the next pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sram_addr <= BASE_ADDR;
            r_sram_data <= 16'h0000;
            r_sram_wr   <= 1'b0;
        end else begin
            r_sram_wr <= w_pop;
            if (w_pop) begin
                r_sram_addr <= r_next_addr;
                r_sram_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Window pointer, commit counter, sticky flags and deferred clear.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_clear_now) begin
            r_next_addr   <= BASE_ADDR;
            r_write_count <= 21'd0;
            r_overflow    <= 1'b0;
            r_wrapped     <= 1'b0;
            r_clear_pend  <= 1'b0;
        end else begin
            // Reaching here with i_clear high means we are mid-write: defer it.
            if (i_clear) begin
                r_clear_pend <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_commit) begin
                r_next_addr <= w_addr_adv;
                if (w_at_last) begin
                    r_wrapped <= 1'b1;
                end
                if (r_write_count != 21'h1FFFFF) begin
                    r_write_count <= r_write_count + 21'd1;
                end
            end
        end
    end

    assign o_sram_addr   = r_sram_addr;
    assign o_sram_data   = r_sram_data;
    assign o_sram_wr     = r_sram_wr;
    assign o_sram_re     = 1'b0;
    assign o_fifo_level  = r_level;
    assign o_write_count = r_write_count;
    assign o_overflow    = r_overflow;
    assign o_wrapped     = r_wrapped;

endmodule
